// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and a helper for sizing the bit counter.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    // Bit-counter width needed to index WIDTH bit positions.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sync_FA.sv
// One-bit full adder with registered sum and carry outputs.
// It has no reset: the controller never consumes its output before writing it.
module sync_FA (
    input  logic clk,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Register the sum and carry of the current bit.
    always_ff @(posedge clk) begin
        sum  <= a ^ b ^ cin;
        cout <= (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one sync_FA LSB first, loops its carry back
// and deserialises the registered sum bits into a held result.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic             c0_r;
    logic [CNT_W-1:0] cnt_r;
    // Bit 0 of a full-width accumulator would never be read, so it is dropped.
    logic [WIDTH-2:0] acc_r;

    logic             load_s;
    logic             step_s;
    logic             finish_s;
    logic             fa_cin_s;
    logic             fa_sum_s;
    logic             fa_cout_s;

    // Bit 0 takes the latched carry-in, so the stale FA carry is never used.
    assign fa_cin_s = (cnt_r == CNT_ZERO) ? c0_r : fa_cout_s;

    sync_FA u_fa (
        .clk  (clk),
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .cin  (fa_cin_s),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state and per-cycle datapath enables.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = S_LAST;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_LAST: begin
                finish_s    = 1'b1;
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, operand shifters, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            c0_r     <= 1'b0;
            cnt_r    <= CNT_ZERO;
            acc_r    <= {(WIDTH-1){1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
            cout_out <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done    <= finish_s;
            if (load_s) begin
                sa_r  <= op_a;
                sb_r  <= op_b;
                c0_r  <= cin_in;
                cnt_r <= CNT_ZERO;
                busy  <= 1'b1;
            end else if (step_s) begin
                sa_r  <= sa_r >> 1;
                sb_r  <= sb_r >> 1;
                cnt_r <= cnt_r + 1'b1;
                // The FA output lags one cycle, so bit k-1 arrives during step k.
                if (cnt_r != CNT_ZERO) begin
                    acc_r <= (acc_r >> 1) | ((WIDTH-1)'(fa_sum_s) << (WIDTH - 2));
                end
            end else if (finish_s) begin
                result   <= {fa_sum_s, acc_r};
                cout_out <= fa_cout_s;
                busy     <= 1'b0;
            end
        end
    end

endmodule
